// File: rtl/rat_pipe_pkg.sv
// rat_pipe_pkg
// Shared types for the fetch front end.
//   PC_W          : default program-counter width
//   pc_t          : program counter at the default width
//   fetch_state_t : fetch controller states (IDLE, RUN, FLUSH)
//   sat_inc16     : saturating 16-bit increment used by the perf counters
package rat_pipe_pkg;

  localparam int PC_W = 10;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  // Stops at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt
// Saturating event counters for the fetch unit.
// Only instantiated when FETCH_PERF_CNT_EN is defined.
// Ports:
//   clk            : system clock, rising edge
//   rst            : asynchronous active-low reset, clears both counters
//   issue          : one fetch entry issued this cycle
//   redir          : one redirect accepted this cycle
//   fetch_count    : issued entries, saturates at 16'hFFFF
//   redirect_count : accepted redirects, saturates at 16'hFFFF
module fetch_perf_cnt
  import rat_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  logic        redir,
  output logic [15:0] fetch_count,
  output logic [15:0] redirect_count
);

  // Each counter advances by at most one per cycle and sticks at full scale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count    <= 16'd0;
      redirect_count <= 16'd0;
    end else begin
      if (issue) fetch_count    <= sat_inc16(fetch_count);
      if (redir) redirect_count <= sat_inc16(redirect_count);
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// Program-counter generator feeding a single-entry fetch slot.
// Each RUN cycle the PC on current_pc is captured into the slot together
// with its branch-cache prediction, and the predicted next PC becomes the
// new current_pc. A redirect from execute overrides everything and forces
// one FLUSH bubble before fetching resumes at redirect_pc.
// Optional feature: define FETCH_PERF_CNT_EN to add the fetch_count and
// redirect_count outputs (saturating 16-bit counters).
// Ports:
//   clk, rst       : clock (rising edge) and asynchronous active-low reset
//   current_pc     : PC presented to the branch cache this cycle
//   jump_pc        : predicted target from the branch cache
//   read_hit       : branch cache hit for current_pc
//   redirect       : mispredict restart request from execute
//   redirect_pc    : restart PC, valid with redirect
//   if_ready       : decode accepts the fetch slot this cycle
//   if_valid       : fetch slot holds a valid entry
//   if_pc          : PC of the slot entry
//   if_pred_taken  : slot entry was predicted taken
//   if_pred_pc     : predicted next PC of the slot entry
module fetch_pc_unit #(
  parameter int              PC_W     = rat_pipe_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] current_pc,
  input  logic [PC_W-1:0] jump_pc,
  input  logic            read_hit,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            if_ready,
  output logic            if_valid,
  output logic [PC_W-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [PC_W-1:0] if_pred_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]     fetch_count,
  output logic [15:0]     redirect_count
`endif
);

  import rat_pipe_pkg::*;

  fetch_state_t    state;
  logic            slot_free;
  logic            issue;
  logic [PC_W-1:0] next_pc;

  // A new entry is taken only in RUN, when the slot is empty or being
  // drained this cycle, and nothing from execute is overriding us.
  // Sequential fall-through wraps modulo 2^PC_W.
  always_comb begin
    slot_free = !if_valid || if_ready;
    issue     = (state == RUN) && slot_free && !redirect;
    next_pc   = read_hit ? jump_pc : current_pc + {{(PC_W-1){1'b0}}, 1'b1};
  end

  // Controller and fetch slot. Redirect wins in every state; IDLE and
  // FLUSH only drain the slot and never advance current_pc. The slot
  // payload is written only on an issue so it holds while if_valid is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      current_pc    <= RESET_PC;
      if_valid      <= 1'b0;
      if_pc         <= {PC_W{1'b0}};
      if_pred_taken <= 1'b0;
      if_pred_pc    <= {PC_W{1'b0}};
    end else if (redirect) begin
      state      <= FLUSH;
      current_pc <= redirect_pc;
      if_valid   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (issue) begin
            if_valid      <= 1'b1;
            if_pc         <= current_pc;
            if_pred_taken <= read_hit;
            if_pred_pc    <= next_pc;
            current_pc    <= next_pc;
          end
        end
        default: begin
          state <= RUN;
          if (if_valid && if_ready) if_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf_cnt (
    .clk            (clk),
    .rst            (rst),
    .issue          (issue),
    .redir          (redirect),
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count)
  );
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit
// Directed testbench for fetch_pc_unit. Inputs change 1ns after each rising
// edge; outputs are compared at that same point, reflecting the edge just
// taken. The slot state is viewed as one packed word:
//   {if_valid, if_pred_taken, if_pc, if_pred_pc, current_pc}
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_pc_unit;

  logic       clk;
  logic       rst;
  logic [9:0] current_pc;
  logic [9:0] jump_pc;
  logic       read_hit;
  logic       redirect;
  logic [9:0] redirect_pc;
  logic       if_ready;
  logic       if_valid;
  logic [9:0] if_pc;
  logic       if_pred_taken;
  logic [9:0] if_pred_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] redirect_count;
`endif

  logic [31:0] obs;
  int checks;
  int failures;

  assign obs = {if_valid, if_pred_taken, if_pc, if_pred_pc, current_pc};

  fetch_pc_unit #(
    .PC_W     (10),
    .RESET_PC (10'h000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .current_pc    (current_pc),
    .jump_pc       (jump_pc),
    .read_hit      (read_hit),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .if_ready      (if_ready),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .if_pred_pc    (if_pred_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count)
`endif
  );

  // 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Redirect for one edge, then leave the FLUSH bubble behind so the next
  // edge issues pc.
  task automatic applyStimulus(input logic [9:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    jump_pc     = 10'h000;
    read_hit    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 10'h000;
    if_ready    = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== 32'h0) begin
      $display("[TB] FAIL reset_state actual=%h required=%h", obs, 32'h0);
      failures++;
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== 32'h0) begin
      $display("[TB] FAIL idle_cycle actual=%h required=%h", obs, 32'h0);
      failures++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = {1'b1, 1'b0, 10'(i), 10'(i + 1), 10'(i + 1)};
      checks++;
      if (obs !== exp) begin
        $display("[TB] FAIL seq_issue_%0d actual=%h required=%h", i, obs, exp);
        failures++;
      end
    end
  endtask

  task automatic test_branch_hit();
    logic [31:0] exp;
    applyStimulus(10'd10);
    read_hit = 1'b1;
    jump_pc  = 10'd20;
    tick();
    read_hit = 1'b0;
    exp = {1'b1, 1'b1, 10'd10, 10'd20, 10'd20};
    checks++;
    if (obs !== exp) begin
      $display("[TB] FAIL branch_hit actual=%h required=%h", obs, exp);
      failures++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp;
    if_ready = 1'b0;
    applyStimulus(10'd5);
    tick();
    exp = {1'b1, 1'b0, 10'd5, 10'd6, 10'd6};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp) begin
        $display("[TB] FAIL stall_hold_%0d actual=%h required=%h", i, obs, exp);
        failures++;
      end
      if (i < 3) tick();
    end
    if_ready = 1'b1;
    tick();
    exp = {1'b1, 1'b0, 10'd6, 10'd7, 10'd7};
    checks++;
    if (obs !== exp) begin
      $display("[TB] FAIL stall_release actual=%h required=%h", obs, exp);
      failures++;
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp;
    // stall on if_pc=6 first, then redirect while decode is not ready
    if_ready    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 10'h100;
    tick();
    redirect = 1'b0;
    exp = {1'b0, 1'b0, 10'd6, 10'd7, 10'h100};
    checks++;
    if (obs !== exp) begin
      $display("[TB] FAIL redirect_kill actual=%h required=%h", obs, exp);
      failures++;
    end
    tick();
    checks++;
    if (obs !== exp) begin
      $display("[TB] FAIL redirect_bubble actual=%h required=%h", obs, exp);
      failures++;
    end
    tick();
    exp = {1'b1, 1'b0, 10'h100, 10'h101, 10'h101};
    checks++;
    if (obs !== exp) begin
      $display("[TB] FAIL redirect_issue actual=%h required=%h", obs, exp);
      failures++;
    end
    // back-to-back redirects: second one lands during FLUSH
    if_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 10'h050;
    tick();
    redirect_pc = 10'h060;
    tick();
    redirect = 1'b0;
    tick();
    exp = {1'b0, 1'b0, 10'h100, 10'h101, 10'h060};
    checks++;
    if (obs !== exp) begin
      $display("[TB] FAIL flush_redirect_bubble actual=%h required=%h", obs, exp);
      failures++;
    end
    tick();
    exp = {1'b1, 1'b0, 10'h060, 10'h061, 10'h061};
    checks++;
    if (obs !== exp) begin
      $display("[TB] FAIL flush_redirect_issue actual=%h required=%h", obs, exp);
      failures++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    if_ready = 1'b1;
    applyStimulus(10'h3FF);
    tick();
    exp = {1'b1, 1'b0, 10'h3FF, 10'h000, 10'h000};
    checks++;
    if (obs !== exp) begin
      $display("[TB] FAIL wrap_pred actual=%h required=%h", obs, exp);
      failures++;
    end
    tick();
    exp = {1'b1, 1'b0, 10'h000, 10'h001, 10'h001};
    checks++;
    if (obs !== exp) begin
      $display("[TB] FAIL wrap_next actual=%h required=%h", obs, exp);
      failures++;
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [31:0] exp;
    if_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== 32'h0) begin
      $display("[TB] FAIL async_reset actual=%h required=%h", obs, 32'h0);
      failures++;
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== 32'h0) begin
      $display("[TB] FAIL reset_no_issue actual=%h required=%h", obs, 32'h0);
      failures++;
    end
    tick();
    exp = {1'b1, 1'b0, 10'd0, 10'd1, 10'd1};
    checks++;
    if (obs !== exp) begin
      $display("[TB] FAIL reset_first_issue actual=%h required=%h", obs, exp);
      failures++;
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_counters();
    rst      = 1'b0;
    if_ready = 1'b1;
    read_hit = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    redirect    = 1'b1;
    redirect_pc = 10'h020;
    tick();
    tick();
    redirect = 1'b0;
    checks++;
    if ({fetch_count, redirect_count} !== {16'd8, 16'd2}) begin
      $display("[TB] FAIL perf_counts actual=%0d/%0d required=8/2", fetch_count, redirect_count);
      failures++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({fetch_count, redirect_count, if_valid} !== {16'd0, 16'd0, 1'b0}) begin
      $display("[TB] FAIL perf_reset actual=%0d/%0d/%0b required=0/0/0", fetch_count, redirect_count, if_valid);
      failures++;
    end
    tick();
    rst = 1'b1;
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_sequential();
    test_branch_hit();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid_stall();
`ifdef FETCH_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
